// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared window constants and compare-network select functions for the median stage
package median_pkg;

    // 3x3 window layout: pixel p sits at row p/ROW_LEN, column p%ROW_LEN
    localparam int WIN_PIX  = 9;
    localparam int WIN_ROWS = 3;
    localparam int ROW_LEN  = 3;

    // Operand selects returned by the compare networks (a, b, c)
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    typedef struct packed {
        logic [1:0] hi;
        logic [1:0] mid;
        logic [1:0] lo;
    } sort_sel_t;

    // Index width for a channel counter; a single channel still needs one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Which of a,b,c is the median, given a>b, b>c, a>c
    function automatic logic [1:0] med3(input logic gt_ab, input logic gt_bc, input logic gt_ac);
        if (gt_ab == gt_bc)
            return SEL_B;
        else if (gt_ab)
            return gt_ac ? SEL_C : SEL_A;
        else
            return gt_ac ? SEL_A : SEL_C;
    endfunction

    // Ascending order of a,b,c expressed as operand selects; ties resolve to any equal operand
    function automatic sort_sel_t sort3(input logic gt_ab, input logic gt_bc, input logic gt_ac);
        sort_sel_t s;
        s.lo  = (!gt_ab && !gt_ac) ? SEL_A : ((gt_ab && !gt_bc) ? SEL_B : SEL_C);
        s.hi  = (!gt_ac && !gt_bc) ? SEL_C : ((gt_bc && !gt_ab) ? SEL_B : SEL_A);
        s.mid = med3(gt_ab, gt_bc, gt_ac);
        return s;
    endfunction

endpackage

// File: rtl/median3x3_core.sv
// rtl/median3x3_core.sv - one channel's three-stage 3x3 median pipeline with shared enable
module median3x3_core
    import median_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic [WIN_PIX*DW-1:0] i_win,
    output logic [DW-1:0]         o_med
);

    logic [WIN_ROWS-1:0][DW-1:0] w_lo, w_mid, w_hi;
    logic [WIN_ROWS-1:0][DW-1:0] r_lo, r_mid, r_hi;
    logic [DW-1:0]               w_a, w_b, w_c, r_a, r_b, r_c;
    logic [DW-1:0]               w_med, r_med;

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] c);
        case (sel)
            SEL_A:   return a;
            SEL_B:   return b;
            default: return c;
        endcase
    endfunction

    function automatic logic [DW-1:0] sel_lo(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        sort_sel_t s;
        s = sort3(a > b, b > c, a > c);
        return pick(s.lo, a, b, c);
    endfunction

    function automatic logic [DW-1:0] sel_mid(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
        sort_sel_t s;
        s = sort3(a > b, b > c, a > c);
        return pick(s.mid, a, b, c);
    endfunction

    function automatic logic [DW-1:0] sel_hi(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        sort_sel_t s;
        s = sort3(a > b, b > c, a > c);
        return pick(s.hi, a, b, c);
    endfunction

    // S1 combinational: sort each window row ascending
    always_comb begin
        w_lo  = '0;
        w_mid = '0;
        w_hi  = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            w_lo[r]  = sel_lo (i_win[(r*ROW_LEN+0)*DW +: DW], i_win[(r*ROW_LEN+1)*DW +: DW],
                               i_win[(r*ROW_LEN+2)*DW +: DW]);
            w_mid[r] = sel_mid(i_win[(r*ROW_LEN+0)*DW +: DW], i_win[(r*ROW_LEN+1)*DW +: DW],
                               i_win[(r*ROW_LEN+2)*DW +: DW]);
            w_hi[r]  = sel_hi (i_win[(r*ROW_LEN+0)*DW +: DW], i_win[(r*ROW_LEN+1)*DW +: DW],
                               i_win[(r*ROW_LEN+2)*DW +: DW]);
        end
    end

    // S2/S3 combinational: column reduction then final median of three candidates
    always_comb begin
        w_a   = sel_hi (r_lo[0],  r_lo[1],  r_lo[2]);
        w_b   = sel_mid(r_mid[0], r_mid[1], r_mid[2]);
        w_c   = sel_lo (r_hi[0],  r_hi[1],  r_hi[2]);
        w_med = sel_mid(r_a, r_b, r_c);
    end

    // All three stages advance together; data needs no reset since valids live in the parent
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_lo  <= w_lo;
            r_mid <= w_mid;
            r_hi  <= w_hi;
            r_a   <= w_a;
            r_b   <= w_b;
            r_c   <= w_c;
            r_med <= w_med;
        end
    end

    assign o_med = r_med;

endmodule

// File: rtl/median_mc_stream.sv
// rtl/median_mc_stream.sv - multi-channel 3x3 median with round-robin serialiser and show-ahead FIFO (MEDIAN_TAG_EN tags words)
module median_mc_stream
    import median_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PROG_FULL  = 12
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [NUM_CH*WIN_PIX*DW-1:0]  s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DW-1:0]                 m_data,
    output logic [idx_w(NUM_CH)-1:0]      m_chan,
    output logic                          m_last,
    output logic                          o_prog_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int IW = idx_w(NUM_CH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef MEDIAN_TAG_EN
    localparam int FW = DW + IW + 1;
`else
    localparam int FW = DW;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PF_C     = CW'(PROG_FULL);

    logic                 r_v1, r_v2, r_v3;
    logic [IW-1:0]        r_idx;
    logic [NUM_CH*DW-1:0] w_meds;
    logic [DW-1:0]        w_med_sel;
    logic                 w_adv, w_pop, w_full, w_push, w_last_wr;
    logic [FW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [FW-1:0]        r_hold;
    logic [FW-1:0]        w_din, w_dout, w_out;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        median3x3_core #(.DW(DW)) u_core (
            .i_clk (i_clk),
            .i_en  (w_adv),
            .i_win (s_data[ch*WIN_PIX*DW +: WIN_PIX*DW]),
            .o_med (w_meds[ch*DW +: DW])
        );
    end

    // Handshake and stall logic: a pop in the same cycle frees a slot, so a full FIFO only stalls without a pop
    always_comb begin
        w_pop     = m_valid && m_ready;
        w_full    = (r_count == DEPTH_C) && !w_pop;
        w_push    = r_v3 && !w_full;
        w_last_wr = w_push && (r_idx == LAST_IDX);
        w_adv     = !(r_v3 && !w_last_wr);
        s_ready   = w_adv && !i_rst;
        w_med_sel = w_meds[r_idx*DW +: DW];
        w_dout    = r_mem[r_rd_ptr];
        w_out     = m_valid ? w_dout : r_hold;
    end

`ifdef MEDIAN_TAG_EN
    assign w_din  = {(r_idx == LAST_IDX), r_idx, w_med_sel};
    assign m_chan = w_out[DW +: IW];
    assign m_last = w_out[FW-1];
`else
    assign w_din  = w_med_sel;
    assign m_chan = '0;
    assign m_last = 1'b0;
`endif

    assign m_valid      = (r_count != '0);
    assign m_data       = w_out[DW-1:0];
    assign o_prog_full  = (r_count >= PF_C);
    assign o_fifo_count = r_count;

    // Pipeline valids, serialiser index and FIFO bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_idx    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_adv) begin
                r_v1 <= s_valid && s_ready;
                r_v2 <= r_v1;
                r_v3 <= r_v2;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_idx    <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= w_dout;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage; pointers are reset elsewhere so stray writes during reset are harmless
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_din;
    end

endmodule

// File: tb/tb_median_mc_stream.sv
// tb/tb_median_mc_stream.sv - directed self-checking bench for median_mc_stream
module tb_median_mc_stream;

    localparam int DW  = 8;
    localparam int NCH = 4;
`ifdef MEDIAN_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid, s_ready, m_valid, m_ready, m_last, o_prog_full;
    logic [NCH*9*DW-1:0] s_data;
    logic [DW-1:0]      m_data;
    logic [1:0]         m_chan;
    logic [4:0]         o_fifo_count;

    logic               s1_valid, s1_ready, m1_valid, m1_ready, m1_last, o1_prog_full;
    logic [9*DW-1:0]    s1_data;
    logic [DW-1:0]      m1_data;
    logic [0:0]         m1_chan;
    logic [4:0]         o1_fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] exp_q[$];
    logic [10:0] rx_q[$];
    bit drv_done;

    always #5 clk = ~clk;

    median_mc_stream #(.DW(DW), .NUM_CH(NCH), .FIFO_DEPTH(16), .PROG_FULL(12)) u_dut (
        .i_clk(clk), .i_rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
        .o_prog_full(o_prog_full), .o_fifo_count(o_fifo_count)
    );

    median_mc_stream #(.DW(DW), .NUM_CH(1), .FIFO_DEPTH(16), .PROG_FULL(12)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
        .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .m_chan(m1_chan), .m_last(m1_last),
        .o_prog_full(o1_prog_full), .o_fifo_count(o1_fifo_count)
    );

    always @(negedge clk)
        if (!rst && m_valid && m_ready)
            rx_q.push_back({m_last, m_chan, m_data});

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] win9(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                         input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                                         input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic logic [71:0] flat(input logic [7:0] v);
        return win9(v, v, v, v, v, v, v, v, v);
    endfunction

    function automatic logic [287:0] rep4(input logic [71:0] w0, input logic [71:0] w1,
                                          input logic [71:0] w2, input logic [71:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic send_beat(input logic [287:0] d, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        bit acc;
        logic [7:0] e[4];
        e = '{e0, e1, e2, e3};
        s_data  = d;
        s_valid = 1'b1;
        acc     = 1'b0;
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            step();
        end
        s_valid = 1'b0;
        if (acc) begin
            for (int c = 0; c < 4; c++)
                exp_q.push_back({TAG && (c == 3), TAG ? 2'(c) : 2'b0, e[c]});
        end else begin
            check_eq("beat_accept_timeout", 0, 1);
        end
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 400 && rx_q.size() < exp_q.size(); t++)
            step();
        repeat (6) step();
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq($sformatf("%s_sample%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_count(input int n);
        for (int t = 0; t < 300 && o_fifo_count != 5'(n); t++)
            step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        s1_valid = 1'b0; s1_data = '0; m1_ready = 1'b1;
        step(); step();
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_count", o_fifo_count, 0);
        check_eq("rst_prog_full", o_prog_full, 0);
        rst = 1'b0;
        step();
        check_eq("post_rst_s_ready", s_ready, 1);

        // 1: classic window, median 5 on every channel
        m_ready = 1'b1;
        send_beat(rep4(win9(9,1,8,2,7,3,6,4,5), win9(9,1,8,2,7,3,6,4,5),
                       win9(9,1,8,2,7,3,6,4,5), win9(9,1,8,2,7,3,6,4,5)), 5, 5, 5, 5);
        drain("t1");

        // 2: per-channel constants, eight beats back to back
        for (int b = 0; b < 8; b++)
            send_beat(rep4(flat(1), flat(11), flat(21), flat(31)), 1, 11, 21, 31);
        drain("t2");

        // 4: extremes, no sign/overflow confusion
        send_beat(rep4(win9(255,0,255,0,255,0,255,0,255), win9(0,255,0,255,0,255,0,255,0),
                       win9(255,0,255,0,255,0,255,0,255), win9(0,255,0,255,0,255,0,255,0)), 255, 0, 255, 0);
        send_beat(rep4(win9(0,0,255,255,0,255,0,255,0), win9(255,255,0,0,255,0,255,0,255),
                       win9(0,255,0,255,0,255,0,255,0), win9(255,0,255,0,255,0,255,0,255)), 0, 255, 0, 255);
        drain("t4");

        // 3: full FIFO backpressure then release
        m_ready  = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 8; b++)
                    send_beat(rep4(flat(8'(100+4*b)), flat(8'(101+4*b)), flat(8'(102+4*b)), flat(8'(103+4*b))),
                              8'(100+4*b), 8'(101+4*b), 8'(102+4*b), 8'(103+4*b));
                drv_done = 1'b1;
            end
        join_none
        wait_count(11);
        check_eq("t3_count11", o_fifo_count, 11);
        check_eq("t3_pf_at11", o_prog_full, 0);
        step();
        check_eq("t3_count12", o_fifo_count, 12);
        check_eq("t3_pf_at12", o_prog_full, 1);
        wait_count(16);
        repeat (5) step();
        check_eq("t3_count16", o_fifo_count, 16);
        check_eq("t3_full_s_ready", s_ready, 0);
        check_eq("t3_full_m_valid", m_valid, 1);
        check_eq("t3_head_data", m_data, 100);
        m_ready = 1'b1;
        for (int t = 0; t < 600 && !drv_done; t++)
            step();
        check_eq("t3_driver_done", drv_done, 1);
        drain("t3");

        // 5: reset mid-operation with 7 words buffered and S2/S3 occupied
        m_ready = 1'b0;
        send_beat(rep4(flat(40), flat(41), flat(42), flat(43)), 40, 41, 42, 43);
        send_beat(rep4(flat(50), flat(51), flat(52), flat(53)), 50, 51, 52, 53);
        send_beat(rep4(flat(60), flat(61), flat(62), flat(63)), 60, 61, 62, 63);
        wait_count(7);
        check_eq("t5_count7", o_fifo_count, 7);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_s_ready", s_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check_eq("t5_m_valid", m_valid, 0);
        check_eq("t5_count", o_fifo_count, 0);
        check_eq("t5_s_ready", s_ready, 1);
        check_eq("t5_m_data", m_data, 0);
        exp_q.delete();
        rx_q.delete();
        m_ready = 1'b1;
        send_beat(rep4(flat(7), flat(17), flat(27), flat(37)), 7, 17, 27, 37);
        check_eq("t5_lat_k", m_valid, 0);
        step();
        check_eq("t5_lat_k1", m_valid, 0);
        step();
        check_eq("t5_lat_k2", m_valid, 0);
        step();
        check_eq("t5_lat_k3", m_valid, 1);
        check_eq("t5_lat_data", m_data, 7);
        drain("t5");

        // 6: single-channel instance, untagged, one sample per beat at full rate
        for (int j = 0; j < 10; j++) begin
            s1_valid = (j < 6);
            s1_data  = win9(8'(j+8), 8'(j), 8'(j+4), 8'(j+2), 8'(j+6), 8'(j+1), 8'(j+3), 8'(j+7), 8'(j+5));
            #1;
            check_eq($sformatf("t6_s_ready%0d", j), s1_ready, 1);
            step();
            if (j < 3 || j == 9) begin
                check_eq($sformatf("t6_idle_valid%0d", j), m1_valid, 0);
            end else begin
                check_eq($sformatf("t6_valid%0d", j), m1_valid, 1);
                check_eq($sformatf("t6_data%0d", j), m1_data, 32'(j + 1));
                check_eq($sformatf("t6_chan%0d", j), m1_chan, 0);
                check_eq($sformatf("t6_last%0d", j), m1_last, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
